// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, default widths and condition opcodes
// Contents: state_t (program-flow FSM states), ADDR_WIDTH_DEF,
//           COND_* opcodes shared with the conditional unit, cond_holds()
package cpu_pkg;
  typedef enum logic [1:0] {RESET_HOLD, FETCH, EXECUTE, HALTED} state_t;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;
  localparam logic [2:0] COND_NE     = 3'b101;
  localparam logic [2:0] COND_GT     = 3'b110;
  localparam logic [2:0] COND_GE     = 3'b111;
  // reference evaluation of an opcode from equal/less flags
  function automatic logic cond_holds(input logic [2:0] op, input logic eq, input logic lt);
    case (op)
      COND_NEVER:  return 1'b0;
      COND_EQ:     return eq;
      COND_LT:     return lt;
      COND_LE:     return lt | eq;
      COND_ALWAYS: return 1'b1;
      COND_NE:     return ~eq;
      COND_GT:     return ~(lt | eq);
      COND_GE:     return ~lt;
      default:     return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/branch_control_if.sv
// branch_control_if: control-path <-> program-flow unit bundle
// master: control FSM side (drives exec_done/jump/cond_result/target/halt_req/call/ret)
// slave:  branch_control side (drives pc/fetch/taken/halted/stack_err)
interface branch_control_if #(parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH_DEF);
  logic exec_done, jump, cond_result, halt_req, call, ret;
  logic [ADDR_WIDTH-1:0] target, pc;
  logic fetch, taken, halted, stack_err;
  modport master(output exec_done, jump, cond_result, target, halt_req, call, ret,
                 input pc, fetch, taken, halted, stack_err);
  modport slave(input exec_done, jump, cond_result, target, halt_req, call, ret,
                output pc, fetch, taken, halted, stack_err);
endinterface

// File: rtl/branch_control_return_stack.sv
// return_stack: DEPTH-entry LIFO of return addresses
// Ports: clock, reset_n (async, active-low), push/din, pop/dout (top of stack), full, empty
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0] sp;
  assign full = sp == SPW'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[IW'(sp - 1'b1)];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop) sp <= sp - 1'b1;
  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clock)
    if (push) mem[IW'(sp)] <= din;
endmodule

// File: rtl/branch_control.sv
// branch_control: program counter, fetch/execute handshake and jump/call/return resolution
// Ports: clock, reset_n (async, active-low), b (branch_control_if.slave)
// Optional return stack built when CALL_STACK_EN is defined; otherwise call/ret
// act as plain steps and stack_err is tied low.
module branch_control
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int STACK_DEPTH = 4
) (
  input logic               clock,
  input logic               reset_n,
  branch_control_if.slave   b
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc_r, pc_n, pc_inc, top;
  logic taken_r, err_r, step, serr, do_call, do_ret, stop, redirect;
  assign step = state == EXECUTE && b.exec_done;
  assign pc_inc = pc_r + 1'b1;
`ifdef CALL_STACK_EN
  logic full, empty;
  assign do_call = b.call & b.cond_result;
  assign do_ret = b.ret;
  assign serr = (b.call & b.ret) | (do_call & full) | (b.ret & empty);
  return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_WIDTH)) u_stack (
    .clock(clock),
    .reset_n(reset_n),
    .push(step & ~stop & do_call),
    .pop(step & ~stop & do_ret),
    .din(pc_inc),
    .dout(top),
    .full(full),
    .empty(empty)
  );
`else
  logic unused;
  assign unused = ^{b.call, b.ret, 32'(STACK_DEPTH)};
  assign do_call = 1'b0;
  assign do_ret = 1'b0;
  assign serr = 1'b0;
  assign top = '0;
`endif
  // halt outranks a stack error, which outranks every redirect
  assign stop = b.halt_req | serr;
  assign redirect = ~stop & (do_ret | do_call | (b.jump & b.cond_result));
  always_comb begin
    state_n = state;
    pc_n = pc_r;
    state_n = state == RESET_HOLD ? FETCH :
              state == FETCH ? EXECUTE :
              step ? (stop ? HALTED : FETCH) : state;
    pc_n = (!step || stop) ? pc_r :
           do_ret ? top :
           redirect ? b.target : pc_inc;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RESET_HOLD;
      pc_r <= '0;
      taken_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      pc_r <= pc_n;
      taken_r <= step & redirect;
      err_r <= err_r | (step & ~b.halt_req & serr);
    end
  assign b.pc = pc_r;
  assign b.fetch = state == FETCH;
  assign b.taken = taken_r;
  assign b.halted = state == HALTED;
  assign b.stack_err = err_r;
endmodule

// File: doc/branch_control.md
# branch_control

Sequential program-flow unit of the 8-bit CPU: owns the program counter and consumes the 1-bit condition result from the conditional unit. It runs a fetch/execute handshake with the control path and resolves conditional jumps (`never`, `eq`, `lt`, `le`, `always`, `ne`, `gt`, `ge` are evaluated upstream). It also handles sequential increment and halt, plus an optional call/return stack. It sits between the control FSM and the instruction-memory address port.

## Interface
- ADDR_WIDTH, 8, program-counter / jump-target width
- STACK_DEPTH, 4, return-stack entries (used only with the stack feature)

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- exec_done  in  1  control path finished executing the current instruction; pulse, sampled only in EXECUTE
- jump  in  1  current instruction is a conditional jump; qualified by exec_done
- cond_result  in  1  condition unit output; 1 = condition holds
- target  in  ADDR_WIDTH  jump/call destination
- halt_req  in  1  current instruction is HALT; qualified by exec_done
- call  in  1  call instruction; qualified by exec_done
- ret  in  1  return instruction; qualified by exec_done
- pc  out  ADDR_WIDTH  instruction-memory address
- fetch  out  1  one-cycle strobe: read memory at pc
- taken  out  1  one-cycle pulse: last step redirected pc
- halted  out  1  core stopped; sticky until reset
- stack_err  out  1  return-stack overflow/underflow/illegal op; sticky until reset

## Operation
- States:
  - RESET_HOLD: entered on reset; left after one clock.
  - FETCH: lasts one cycle; fetch=1.
  - EXECUTE: waits for exec_done.
  - HALTED: terminal.
- Transitions:
  - RESET_HOLD→FETCH.
  - FETCH→EXECUTE.
  - EXECUTE with exec_done→FETCH, or →HALTED on halt or stack error.
- Next-pc priority when exec_done=1 in EXECUTE:
  - halt_req: pc unchanged, go to HALTED.
  - Stack error: pc unchanged, stack_err=1, go to HALTED.
  - ret: pc = popped entry.
  - call && cond_result: push pc+1, pc = target.
  - jump && cond_result: pc = target.
  - Otherwise: pc = pc+1.
- taken=1 for the cycle after any redirect (ret, taken call, taken jump); 0 otherwise.
- pc+1 wraps modulo 2^ADDR_WIDTH (0xFF→0x00 at default width); the pushed return address wraps the same way.
- jump/call/ret/halt_req are ignored outside EXECUTE or without exec_done.
- Stack error cases: call with cond_result=1 on a full stack; ret on an empty stack; call and ret both 1.

## Timing
- Reset values: pc=0, fetch=0, taken=0, halted=0, stack_err=0; state RESET_HOLD; stack pointer 0.
- First fetch strobe is in the second clock after reset_n deasserts.
- pc is stable from the FETCH cycle through EXECUTE. Memory read is synchronous: the instruction is valid in the first EXECUTE cycle.
- Minimum instruction period: 2 cycles (FETCH plus a one-cycle EXECUTE with exec_done=1).
- The new pc appears in the FETCH cycle that immediately follows exec_done.
- halted rises in the cycle after the halting exec_done. fetch never asserts again until reset.
- Reset asserted mid-instruction: all outputs go to their reset values immediately (asynchronous); any pending exec_done is discarded.

## Configuration
- CALL_STACK_EN defined:
  - STACK_DEPTH-entry LIFO return stack is built.
  - call/ret behave as above; stack_err is live.
- Not defined:
  - call and ret are ignored; a call/ret instruction behaves as plain pc+1.
  - stack_err is tied to 0.
  - No stack storage is synthesized.
  - Port list is identical in both builds.

## Structure
- Shared package cpu_pkg:
  - state enum (RESET_HOLD, FETCH, EXECUTE, HALTED)
  - default ADDR_WIDTH constant
  - condition opcode constants 3'b000–3'b111, shared with the conditional unit
- Sub-module return_stack (ports: push, pop, din, dout, full, empty), instantiated only under CALL_STACK_EN.

## Test plan
- Reset, then exec_done each EXECUTE with no jump → pc sequence 0,1,2,3; fetch pulses every 2 cycles; taken stays 0.
- At pc=5, jump=1, cond_result=1, target=0x40 → next fetch at pc=0x40, taken=1 for one cycle. Repeat with cond_result=0 → pc=6, taken=0.
- pc=0xFF, plain step → pc=0x00, no error.
- halt_req=1 together with jump=1 at pc=7 → halted=1, pc stays 7, fetch never reasserts.
- CALL_STACK_EN build:
  - call target=0x20 at pc=3 → pc=0x20; later ret → pc=4.
  - Five nested calls → stack_err=1 and halted=1.
  - ret on an empty stack → stack_err=1.
- reset_n pulsed low while in EXECUTE at pc=0x12 → pc=0 and all outputs 0 immediately; first fetch occurs 2 cycles after release.
